// File: rtl/ofmap_piso_ctrl_pkg.sv
// Shared types for the ofmap PISO sequencing controller.
package ofmap_piso_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WAIT  = 3'd1,
    FIRST = 3'd2,
    XFER  = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/ofmap_piso_ctrl_counter.sv
// Saturating up-counter with synchronous clear, used for the per-tile vector counts.
module ofmap_piso_ctrl_counter #(
  parameter int             WID       = 16,
  parameter logic [WID-1:0] MAX_COUNT = '1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clr,
  input  logic           inc,
  output logic [WID-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != MAX_COUNT)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/ofmap_piso_ctrl.sv
// Sequencing controller for the ofmap PISO: takes chained vectors, drives load/start/en_PISO
// and pulses tile_done together with the last serial word of a tile.
module ofmap_piso_ctrl
  import ofmap_piso_ctrl_pkg::*;
#(
  parameter int OC0         = 4,
  parameter int VEC_CNT_WID = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   tile_start,
  input  logic [VEC_CNT_WID-1:0] cfg_num_vec,
  input  logic                   chained_vld,
  output logic                   chained_rdy,
  output logic                   load,
  output logic                   start,
  output logic                   en_PISO,
  input  logic                   ofmap_rdy,
  input  logic                   chaining_last_one,
  output logic                   busy,
  output logic                   tile_done,
  output logic [2:0]             state_dbg
);

  // The XFER exit relies on chaining_last_one arriving after the FIRST shift.
  if (OC0 < 2) begin : g_oc0_check
    $error("ofmap_piso_ctrl: OC0 must be at least 2");
  end

  state_t                 state;
  state_t                 nxt;
  logic [VEC_CNT_WID-1:0] num_vec;
  logic [VEC_CNT_WID-1:0] ld_cnt;
  logic [VEC_CNT_WID-1:0] dn_cnt;
  logic                   hold_full;
  logic                   acc;
  logic                   cnt_clr;
  logic                   vec_done;
  logic                   last_vec;

  assign acc      = en_PISO && ofmap_rdy;
  assign cnt_clr  = tile_start && (state == IDLE);
  assign vec_done = (state == XFER) && chaining_last_one;
  assign last_vec = (dn_cnt == num_vec - 1'b1);

  // Handshake: a vector moves in every cycle with chained_vld && chained_rdy (that cycle is
  // load); chained_vld must hold with stable data until then, chained_rdy never looks at vld.
  assign chained_rdy = busy && (state != DONE) && !hold_full && (ld_cnt < num_vec);
  assign load        = chained_vld && chained_rdy;
  assign state_dbg   = state;

  ofmap_piso_ctrl_counter #(
    .WID       (VEC_CNT_WID),
    .MAX_COUNT ({VEC_CNT_WID{1'b1}})
  ) u_ld_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (load),
    .count (ld_cnt)
  );

  ofmap_piso_ctrl_counter #(
    .WID       (VEC_CNT_WID),
    .MAX_COUNT ({VEC_CNT_WID{1'b1}})
  ) u_dn_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (vec_done),
    .count (dn_cnt)
  );

  always_comb begin
    nxt = state;
    case (state)
      IDLE:  if (tile_start) nxt = (cfg_num_vec == '0) ? DONE : WAIT;
      WAIT:  if (load) nxt = FIRST;
      FIRST: if (acc) nxt = XFER;
      XFER: begin
        // A vector already held (or arriving now) chains straight into FIRST with no bubble.
        if (chaining_last_one) begin
          if (last_vec)               nxt = DONE;
          else if (hold_full || load) nxt = FIRST;
          else                        nxt = WAIT;
        end
      end
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      num_vec   <= '0;
      hold_full <= 1'b0;
      busy      <= 1'b0;
      en_PISO   <= 1'b0;
      start     <= 1'b0;
      tile_done <= 1'b0;
    end else begin
      state     <= nxt;
      busy      <= (nxt != IDLE);
      en_PISO   <= (nxt == FIRST) || (nxt == XFER);
      start     <= (nxt == FIRST);
      tile_done <= (nxt == DONE);
      if (cnt_clr) num_vec <= cfg_num_vec;
      if (cnt_clr)            hold_full <= 1'b0;
      else if (load)          hold_full <= 1'b1;
      else if (acc && start)  hold_full <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ofmap_piso_ctrl.sv
// Bench for ofmap_piso_ctrl paired with a behavioural ofmap PISO; serial words are scoreboarded.
module tb_ofmap_piso_ctrl;

  localparam int OC0    = 4;
  localparam int DW     = 8;
  localparam int VW     = 16;
  localparam int BUDGET = 300;

  typedef struct {
    logic [DW-1:0] data;
    logic          done;
    int            cyc;
  } got_t;

  logic          clk;
  logic          rst_n;
  logic          tile_start;
  logic [VW-1:0] cfg_num_vec;
  logic          chained_vld;
  logic          chained_rdy;
  logic          load;
  logic          start;
  logic          en_PISO;
  logic          ofmap_rdy;
  logic          chaining_last_one;
  logic          busy;
  logic          tile_done;
  logic [2:0]    state_dbg;

  // PISO model state
  logic [OC0*DW-1:0] chained_data;
  logic [OC0*DW-1:0] hold_reg;
  logic [OC0*DW-1:0] sh_reg;
  int                piso_cnt;
  int                words_left;
  logic              acc;
  logic              ofmap_vld;
  logic [DW-1:0]     ofmap_data;

  logic [DW:0] exp_q[$];
  got_t        got_q[$];
  int          hs_cyc_q[$];

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  int n_load = 0;
  int n_en = 0;
  int n_done = 0;
  int words_seen = 0;
  int last_load_cyc = 0;

  ofmap_piso_ctrl #(
    .OC0         (OC0),
    .VEC_CNT_WID (VW)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .tile_start        (tile_start),
    .cfg_num_vec       (cfg_num_vec),
    .chained_vld       (chained_vld),
    .chained_rdy       (chained_rdy),
    .load              (load),
    .start             (start),
    .en_PISO           (en_PISO),
    .ofmap_rdy         (ofmap_rdy),
    .chaining_last_one (chaining_last_one),
    .busy              (busy),
    .tile_done         (tile_done),
    .state_dbg         (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish, compared=%0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

  // ---------------- behavioural PISO ----------------
  assign acc               = en_PISO && ofmap_rdy;
  assign chaining_last_one = acc && (piso_cnt == OC0 - 1);
  assign ofmap_vld         = (words_left != 0);
  assign ofmap_data        = sh_reg[DW-1:0];

  always @(posedge clk) begin
    if (!rst_n) begin
      hold_reg   <= '0;
      sh_reg     <= '0;
      piso_cnt   <= 0;
      words_left <= 0;
    end else begin
      if (load) hold_reg <= chained_data;
      if (acc) piso_cnt <= (piso_cnt == OC0 - 1) ? 0 : piso_cnt + 1;
      if (acc && start) begin
        sh_reg     <= hold_reg;
        words_left <= OC0;
      end else begin
        if (acc) sh_reg <= sh_reg >> DW;
        if (ofmap_vld && ofmap_rdy) words_left <= words_left - 1;
      end
    end
  end

  // ---------------- output monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (ofmap_vld && ofmap_rdy) got_q.push_back('{ofmap_data, tile_done, cyc});
      if (load) n_load++;
      if (en_PISO) n_en++;
      if (tile_done) n_done++;
    end
  end

  // ---------------- checkers ----------------
  task automatic check1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic checkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check1({tag, "_chained_rdy"}, chained_rdy, 1'b0);
    check1({tag, "_load"}, load, 1'b0);
    check1({tag, "_start"}, start, 1'b0);
    check1({tag, "_en_PISO"}, en_PISO, 1'b0);
    check1({tag, "_busy"}, busy, 1'b0);
    check1({tag, "_tile_done"}, tile_done, 1'b0);
    checkw({tag, "_state"}, 32'(state_dbg), 32'd0);
  endtask

  // Scoreboard: pop one expected word per observed serial word.
  task automatic pump();
    got_t        g;
    logic [DW:0] e;
    while (got_q.size() > 0) begin
      g = got_q.pop_front();
      words_seen++;
      hs_cyc_q.push_back(g.cyc);
      check1("word_expected", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checkw("word_data", 32'(g.data), 32'(e[DW-1:0]));
        check1("tile_done_with_word", g.done, e[DW]);
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic pulse_tile_start(input int nv);
    cfg_num_vec = VW'(nv);
    tile_start  = 1'b1;
    @(posedge clk); #1;
    tile_start  = 1'b0;
  endtask

  task automatic send_vec(input logic [OC0*DW-1:0] vec, input logic last, input string tag);
    int   n;
    logic took;
    n    = 0;
    took = 1'b0;
    chained_data = vec;
    chained_vld  = 1'b1;
    while (!took && n < BUDGET) begin
      @(negedge clk);
      if (chained_rdy) begin
        check1({tag, "_load"}, load, 1'b1);
        last_load_cyc = cyc;
        for (int k = 0; k < OC0; k++)
          exp_q.push_back({last && (k == OC0 - 1), vec[k*DW +: DW]});
        took = 1'b1;
      end else begin
        check1({tag, "_no_load_while_not_rdy"}, load, 1'b0);
      end
      n++;
      @(posedge clk); #1;
    end
    chained_vld = 1'b0;
    check1({tag, "_accepted"}, took, 1'b1);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk); #1;
      pump();
      n++;
    end while ((exp_q.size() != 0 || busy) && n < BUDGET);
    check1({tag, "_completes"}, n < BUDGET, 1'b1);
    checkw({tag, "_words_left"}, exp_q.size(), 0);
  endtask

  function automatic logic [OC0*DW-1:0] rand_vec();
    logic [OC0*DW-1:0] v;
    for (int k = 0; k < OC0; k++) v[k*DW +: DW] = DW'($urandom_range(0, 255));
    return v;
  endfunction

  // ---------------- directed sequence ----------------
  initial begin
    int               n;
    int               load0;
    int               en0;
    int               done0;
    logic [7:0]       rdy_pat;
    logic [OC0*DW-1:0] v;

    rst_n        = 1'b0;
    tile_start   = 1'b0;
    cfg_num_vec  = '0;
    chained_vld  = 1'b0;
    chained_data = '0;
    ofmap_rdy    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_idle("after_release");

    // 1) single vector, words 1..4, two-cycle latency from load
    hs_cyc_q.delete();
    done0 = n_done;
    pulse_tile_start(1);
    check1("t1_busy", busy, 1'b1);
    send_vec({8'd4, 8'd3, 8'd2, 8'd1}, 1'b1, "t1");
    drain("t1");
    checkw("t1_word_count", hs_cyc_q.size(), 4);
    if (hs_cyc_q.size() == 4) begin
      checkw("t1_first_word_cycle", hs_cyc_q[0], last_load_cyc - 3 + 5);
      checkw("t1_last_word_cycle", hs_cyc_q[3], last_load_cyc + 5);
    end
    checkw("t1_done_count", n_done - done0, 1);

    // 2) three vectors streamed with chained_vld held high: 12 words, no gaps
    hs_cyc_q.delete();
    load0 = n_load;
    done0 = n_done;
    pulse_tile_start(3);
    for (int i = 0; i < 3; i++) begin
      v = rand_vec();
      send_vec(v, i == 2, "t2");
    end
    drain("t2");
    checkw("t2_loads", n_load - load0, 3);
    checkw("t2_word_count", hs_cyc_q.size(), 12);
    if (hs_cyc_q.size() == 12)
      checkw("t2_gap_free_span", hs_cyc_q[11] - hs_cyc_q[0], 11);
    checkw("t2_done_count", n_done - done0, 1);

    // 3) ofmap_rdy toggling during a vector: order kept, nothing lost or doubled
    hs_cyc_q.delete();
    rdy_pat = 8'b1001_0010;
    pulse_tile_start(1);
    send_vec({8'hd4, 8'hc3, 8'hb2, 8'ha1}, 1'b1, "t3");
    for (int i = 0; i < 8; i++) begin
      ofmap_rdy = rdy_pat[7-i];
      @(posedge clk); #1;
    end
    ofmap_rdy = 1'b1;
    drain("t3");
    checkw("t3_word_count", hs_cyc_q.size(), 4);

    // 4) zero-vector tile: tile_done straight after the accepted tile_start, no load/en_PISO
    load0 = n_load;
    en0   = n_en;
    done0 = n_done;
    chained_data = 32'h5a5a5a5a;
    chained_vld  = 1'b1;
    pulse_tile_start(0);
    @(negedge clk);
    check1("t4_tile_done", tile_done, 1'b1);
    checkw("t4_state_done", 32'(state_dbg), 32'd4);
    @(negedge clk);
    check1("t4_done_one_cycle", tile_done, 1'b0);
    checkw("t4_state_idle", 32'(state_dbg), 32'd0);
    chained_vld = 1'b0;
    @(posedge clk); #1;
    checkw("t4_no_load", n_load - load0, 0);
    checkw("t4_no_en_PISO", n_en - en0, 0);
    checkw("t4_done_count", n_done - done0, 1);

    // 5) reset for one cycle after the second word, then a clean tile
    done0      = n_done;
    words_seen = 0;
    pulse_tile_start(1);
    send_vec({8'h14, 8'h13, 8'h12, 8'h11}, 1'b1, "t5");
    n = 0;
    while (words_seen < 2 && n < BUDGET) begin
      @(negedge clk); #1;
      pump();
      n++;
    end
    checkw("t5_two_words_seen", words_seen, 2);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_idle("t5_after_reset");
    exp_q.delete();
    got_q.delete();
    repeat (3) @(negedge clk);
    checkw("t5_no_tile_done", n_done - done0, 0);
    checkw("t5_still_idle", 32'(state_dbg), 32'd0);
    @(posedge clk); #1;
    hs_cyc_q.delete();
    pulse_tile_start(1);
    send_vec({8'h24, 8'h23, 8'h22, 8'h21}, 1'b1, "t5b");
    drain("t5b");
    checkw("t5b_word_count", hs_cyc_q.size(), 4);
    checkw("t5b_done_count", n_done - done0, 1);

    // 6) tile_start while busy is ignored: the original 2-vector count completes
    hs_cyc_q.delete();
    load0 = n_load;
    done0 = n_done;
    pulse_tile_start(2);
    send_vec(rand_vec(), 1'b0, "t6a");
    cfg_num_vec = VW'(5);
    tile_start  = 1'b1;
    @(posedge clk); #1;
    tile_start  = 1'b0;
    send_vec(rand_vec(), 1'b1, "t6b");
    drain("t6");
    repeat (4) @(negedge clk);
    checkw("t6_loads", n_load - load0, 2);
    checkw("t6_word_count", hs_cyc_q.size(), 8);
    checkw("t6_done_count", n_done - done0, 1);
    check1("t6_idle_busy", busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
